// File: rtl/acumulador_somas_if.sv
// acumulador_somas_if: sum input stream, block-total output stream
// and the abort line of the accumulator stage.
interface acumulador_somas_if #(
    parameter int LARG_ENT = 9,
    parameter int LARG_ACC = 16
);
    logic [LARG_ENT-1:0] s_in;
    logic                in_valid;
    logic                in_ready;
    logic                limpar;
    logic [LARG_ACC-1:0] total;
    logic [7:0]          contagem;
    logic                out_valid;
    logic                out_ready;
    logic                overflow;

    modport master (
        output s_in, in_valid, limpar, out_ready,
        input  in_ready, total, contagem, out_valid, overflow
    );

    modport slave (
        input  s_in, in_valid, limpar, out_ready,
        output in_ready, total, contagem, out_valid, overflow
    );
endinterface

// File: rtl/acumulador_somas.sv
// acumulador_somas: sums NUM_AMOSTRAS adder results per block.
// Optional macro SATURACAO_EN: saturate instead of wrap on carry.
module acumulador_somas #(
    parameter int LARG_ENT     = 9,
    parameter int LARG_ACC     = 16,
    parameter int NUM_AMOSTRAS = 4
) (
    input logic               clk,
    input logic               rst,
    acumulador_somas_if.slave bus
);
    typedef enum logic {ACUM, ENTREGA} estado_t;

    localparam int         LS     = LARG_ACC + 1;
    localparam logic [7:0] ULTIMA = 8'(NUM_AMOSTRAS - 1);

    estado_t             estado, prox;
    logic [LARG_ACC-1:0] acc, acc_novo, total_q;
    logic [LARG_ACC:0]   soma;
    logic [7:0]          cont;
    logic                ovf, ovf_novo, ovf_q;
    logic                aceita, fecha;

    // one extra bit catches the carry of this add
    always_comb begin
        soma     = {1'b0, acc} + LS'(bus.s_in);
        ovf_novo = ovf | soma[LARG_ACC];
`ifdef SATURACAO_EN
        acc_novo = ovf_novo ? '1 : soma[LARG_ACC-1:0];
`else
        acc_novo = soma[LARG_ACC-1:0];
`endif
        aceita   = (estado == ACUM) && bus.in_valid && !bus.limpar;
        fecha    = aceita && (cont == ULTIMA);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) estado <= ACUM;
        else     estado <= prox;
    end

    // next state; handshake outputs depend on state only
    always_comb begin
        prox          = estado;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (estado)
            ACUM: begin
                bus.in_ready = 1'b1;
                if (fecha) prox = ENTREGA;
            end
            ENTREGA: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) prox = ACUM;
            end
            default: prox = ACUM;
        endcase
    end

    // accumulate; close block into total on the last sum
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cont    <= '0;
            ovf     <= 1'b0;
            total_q <= '0;
            ovf_q   <= 1'b0;
        end else if (estado == ACUM) begin
            if (bus.limpar) begin
                acc  <= '0;
                cont <= '0;
                ovf  <= 1'b0;
            end else if (fecha) begin
                total_q <= acc_novo;
                ovf_q   <= ovf_novo;
                acc     <= '0;
                cont    <= '0;
                ovf     <= 1'b0;
            end else if (aceita) begin
                acc  <= acc_novo;
                cont <= cont + 8'd1;
                ovf  <= ovf_novo;
            end
        end
    end

    assign bus.total    = total_q;
    assign bus.overflow = ovf_q;
    assign bus.contagem = cont;
endmodule

// File: tb/tb_acumulador_somas.sv
// tb_acumulador_somas: scoreboard bench for the block accumulator.
// Covers defaults, narrow accumulator overflow and one-sum blocks.
module tb_acumulador_somas;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    acumulador_somas_if #(.LARG_ENT(9), .LARG_ACC(16)) b0();
    acumulador_somas_if #(.LARG_ENT(9), .LARG_ACC(10)) b1();
    acumulador_somas_if #(.LARG_ENT(9), .LARG_ACC(16)) b2();

    acumulador_somas #(.LARG_ENT(9), .LARG_ACC(16), .NUM_AMOSTRAS(4))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    acumulador_somas #(.LARG_ENT(9), .LARG_ACC(10), .NUM_AMOSTRAS(4))
        dut1 (.clk(clk), .rst(rst), .bus(b1));
    acumulador_somas #(.LARG_ENT(9), .LARG_ACC(16), .NUM_AMOSTRAS(1))
        dut2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct packed {
        logic [15:0] t;
        logic        o;
    } esp_t;

    esp_t   fila[$];
    int     n_testes = 0;
    int     n_falhas = 0;
    longint m_acc, m_larg;
    int     m_cnt, m_n;
    logic   m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] esp);
        n_testes++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    function automatic void modelo_zera();
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endfunction

    // true running sum, then wrapped or clipped to the accumulator width
    function automatic void modelo(input int v);
        longint lim, s;
        esp_t   e;
        lim = longint'(1) << m_larg;
        s   = m_acc + longint'(v);
        if (s >= lim) begin
            m_ovf = 1'b1;
`ifdef SATURACAO_EN
            s = lim - 1;
`else
            s = s - lim;
`endif
        end
        m_acc = s;
        m_cnt++;
        if (m_cnt == m_n) begin
            e.t = 16'(m_acc);
            e.o = m_ovf;
            fila.push_back(e);
            modelo_zera();
        end
    endfunction

    task automatic envia0(input int v);
        @(negedge clk);
        b0.s_in     = 9'(v);
        b0.in_valid = 1'b1;
        chk("in_ready0", b0.in_ready, 1);
        @(posedge clk);
        #1;
        b0.in_valid = 1'b0;
        modelo(v);
    endtask

    task automatic recebe0();
        esp_t e;
        int   k = 0;
        while (!b0.out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("out_valid0_timeout", b0.out_valid, 1);
        if (fila.size() == 0) begin
            chk("fila0_vazia", 0, 1);
        end else begin
            e = fila.pop_front();
            chk("total0", b0.total, e.t);
            chk("overflow0", b0.overflow, e.o);
        end
        b0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b0.out_ready = 1'b0;
        chk("out_valid0_baixo", b0.out_valid, 0);
        chk("in_ready0_volta", b0.in_ready, 1);
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, "_total"}, b0.total, 0);
        chk({tag, "_cont"}, b0.contagem, 0);
        chk({tag, "_valid"}, b0.out_valid, 0);
        chk({tag, "_ovf"}, b0.overflow, 0);
        chk({tag, "_ready"}, b0.in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        esp_t e;
        b0.s_in = '0; b0.in_valid = 0; b0.limpar = 0; b0.out_ready = 0;
        b1.s_in = '0; b1.in_valid = 0; b1.limpar = 0; b1.out_ready = 0;
        b2.s_in = '0; b2.in_valid = 0; b2.limpar = 0; b2.out_ready = 0;
        m_larg = 16;
        m_n    = 4;
        modelo_zera();

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero0("reset");

        // basic block of adder results
        envia0(0);
        envia0(2);
        chk("cont_2", b0.contagem, 2);
        envia0(127);
        envia0(510);
        chk("bloco_valid", b0.out_valid, 1);
        chk("bloco_ready", b0.in_ready, 0);
        chk("bloco_cont", b0.contagem, 0);
        chk("bloco_total", b0.total, 639);

        // backpressure: held output, no input accepted
        @(negedge clk);
        b0.in_valid = 1'b1;
        b0.s_in     = 9'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_total", b0.total, 639);
            chk("hold_ready", b0.in_ready, 0);
            chk("hold_cont", b0.contagem, 0);
        end
        b0.in_valid = 1'b0;
        recebe0();
        chk("pos_hold_cont", b0.contagem, 0);

        // abort partial block, same-cycle input dropped
        envia0(3);
        envia0(4);
        chk("pre_limpar_cont", b0.contagem, 2);
        @(negedge clk);
        b0.limpar   = 1'b1;
        b0.in_valid = 1'b1;
        b0.s_in     = 9'd7;
        @(posedge clk);
        #1;
        b0.limpar   = 1'b0;
        b0.in_valid = 1'b0;
        modelo_zera();
        chk("limpar_cont", b0.contagem, 0);
        for (int i = 0; i < 4; i++) envia0(1);
        recebe0();

        // reset during delivery
        for (int i = 0; i < 4; i++) envia0(10);
        chk("entrega_valid", b0.out_valid, 1);
        void'(fila.pop_back());
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero0("rst_entrega");

        // reset mid-block
        for (int i = 0; i < 3; i++) envia0(20);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelo_zera();
        chk_zero0("rst_meio");
        envia0(100);
        envia0(200);
        envia0(300);
        envia0(511);
        recebe0();

        // narrow accumulator: 4 x 510 exceeds 10 bits
        m_larg = 10;
        m_n    = 4;
        modelo_zera();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b1.s_in     = 9'd510;
            b1.in_valid = 1'b1;
            @(posedge clk);
            #1;
            b1.in_valid = 1'b0;
            modelo(510);
        end
        chk("acc10_valid", b1.out_valid, 1);
        if (fila.size() == 0) begin
            chk("fila1_vazia", 0, 1);
        end else begin
            e = fila.pop_front();
            chk("acc10_total", b1.total, e.t);
            chk("acc10_ovf", b1.overflow, e.o);
        end
        b1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b1.out_ready = 1'b0;
        chk("acc10_fim", b1.out_valid, 0);

        // one sum per block, gapped valid, bubble after handshake
        m_larg = 16;
        m_n    = 1;
        modelo_zera();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b2.s_in     = 9'd256;
            b2.in_valid = 1'b1;
            @(posedge clk);
            #1;
            modelo(256);
            chk("n1_valid", b2.out_valid, 1);
            chk("n1_ready", b2.in_ready, 0);
            if (fila.size() == 0) begin
                chk("fila2_vazia", 0, 1);
            end else begin
                e = fila.pop_front();
                chk("n1_total", b2.total, e.t);
                chk("n1_ovf", b2.overflow, e.o);
            end
            b2.out_ready = 1'b1;
            @(posedge clk);
            #1;
            b2.out_ready = 1'b0;
            b2.in_valid  = 1'b0;
            chk("n1_bolha", b2.out_valid, 0);
            chk("n1_ready_volta", b2.in_ready, 1);
            @(posedge clk);
            #1;
            chk("n1_ocioso", b2.out_valid, 0);
        end

        chk("fila_final", fila.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end
endmodule
